simeck_key_schedule: RTL and testbench
======================================

Name: simeck_key_schedule

Overview:
- Iterative Simeck key-schedule generator, upstream of the round datapath; supplies one round key (the C input of the round stage) per accepted handshake.
- Loads a 4-word master key, then emits round keys k0..k(ROUNDS-1) in order under valid/ready flow control.
- The update uses the same f(x) = (x & rol5(x)) ^ rol1(x) as the round stage, with constant 2^DATAW-4 ^ z_i.

Parameters:
- DATAW, 16: word width n (16/24/32 for Simeck32/48/64).
- ROUNDS, 32: number of round keys emitted (32/36/44).
- LFSRW, 5: z-sequence LFSR width (5 for z0, 6 for z1).
- LFSRTAP, 2: feedback tap index (2 for z0, 1 for z1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  4*DATAW  master key; word 0 = key_in[DATAW-1:0] = t0.
- key_valid  in  1  master key offered.
- key_ready  out  1  block can accept a key (IDLE).
- rk  out  DATAW  current round key.
- rk_idx  out  $clog2(ROUNDS)  index of rk.
- rk_valid  out  1  rk valid.
- rk_last  out  1  rk is key ROUNDS-1.
- rk_ready  in  1  consumer accepts rk.

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous and active-high. On rst: state=IDLE, t0..t3=0, LFSR=all ones, counter=0, rk=0, rk_idx=0, rk_valid=0, rk_last=0, key_ready=1.
- States: IDLE, RUN.
- IDLE: key_ready=1, rk_valid=0. key_valid&key_ready at an edge loads t0..t3 from key_in, LFSR=all ones, counter=0, state=RUN. First rk_valid is asserted the cycle after acceptance (1-cycle latency), with rk=t0 and rk_idx=0.
- RUN: key_ready=0, rk_valid=1, rk=t0, rk_idx=counter, rk_last=(counter==ROUNDS-1). key_valid is ignored.
- Advance on rk_valid&rk_ready:
  - t0<=t1, t1<=t2, t2<=t3.
  - t3<=t0 ^ f(t1) ^ {{(DATAW-1){1'b1}} with bit1=0, bit0=z}, i.e. (2^DATAW-4) | z, with z=LFSR[0].
  - LFSR<={LFSR[0]^LFSR[LFSRTAP], LFSR[LFSRW-1:1]}.
  - counter++.
- Rotations are modulo DATAW; all arithmetic is XOR/AND only, no carries.
- Handshake at rk_last returns to IDLE: rk_valid=0, key_ready=1 the next cycle. The counter never wraps past ROUNDS-1.
- Backpressure: with rk_ready=0, rk, rk_idx and rk_last hold stable indefinitely.
- rst mid-RUN: abandons the sequence, outputs return to reset values, and the next key load starts from k0.

Optional Feature:
- Macro: SIMECK_KS_REWIND_EN.
- With the macro: adds input port rewind (1 bit) and a 4*DATAW shadow register holding the last loaded master key. rewind=1 in IDLE reloads t0..t3 from the shadow, resets LFSR and counter, and enters RUN as a key load would (no key_valid needed). rewind in RUN restarts from k0 on the next cycle. If rewind and key_valid coincide in IDLE, key_valid wins. The shadow resets to 0.
- Without the macro: no rewind port and no shadow register.

Decomposition:
- Package simeck_pkg: state enum (IDLE, RUN); function f(x) with rol5/rol1; round-constant base function const_base(DATAW) = 2^DATAW-4; LFSR init constant (all ones).
- Sub-module simeck_zseq(LFSRW, LFSRTAP): z-sequence LFSR with load/advance inputs and a z output.

Test Plan:
- Simeck32/64, key_in=64'h1918_1110_0908_0100, rk_ready=1 -> rk=0100, 0908, 1110, 1918, EDED for idx 0..4.
- Same run -> z bits (bit0 of rk^t0^f(t1) for idx≥4) follow 0x9A42BB1F LSB-first (1,1,1,1,1,0,0,0,1,1,…); rk_last=1 only at idx 31; key_ready=1 the cycle after.
- Randomised rk_ready toggling -> rk/rk_idx stable while stalled; sequence identical to the no-stall run; exactly 32 handshakes.
- key_valid=1 held throughout RUN with a different key -> ignored; the second key is accepted only after return to IDLE.
- rst asserted at idx 10 -> rk_valid=0 and rk=0 next cycle; a reload then yields rk=0100 at idx 0.
- SIMECK_KS_REWIND_EN: rewind at idx 7 -> next cycle rk=0100, idx 0. Rewind in IDLE after completion -> full identical sequence repeats.

Source files
------------

// File: rtl/simeck_pkg.sv
// rtl/simeck_pkg.sv - Simeck key-schedule shared types and word helpers
package simeck_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic LFSR_INIT_BIT = 1'b1;

   // Rotations operate on the low w bits of a 64-bit carrier; bits at and above w read as 0.
   function automatic logic [63:0] rol(input logic [63:0] x, input int s, input int w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < w) r[i] = x[6'((i + w - s) % w)];
      end
      return r;
   endfunction

   function automatic logic [63:0] f(input logic [63:0] x, input int w);
      return (x & rol(x, 5, w)) ^ rol(x, 1, w);
   endfunction

   function automatic logic [63:0] const_base(input int w);
      logic [63:0] c;
      c = '0;
      for (int i = 2; i < 64; i++) begin
         if (i < w) c[i] = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/simeck_zseq.sv
// rtl/simeck_zseq.sv - z-sequence LFSR feeding the round-constant LSB
module simeck_zseq
   import simeck_pkg::*;
#(
   parameter int LFSRW   = 5,
   parameter int LFSRTAP = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_adv,
   output logic o_z
);

   logic [LFSRW-1:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (rst || i_load) begin
         r_lfsr <= {LFSRW{LFSR_INIT_BIT}};
      end else if (i_adv) begin
         r_lfsr <= {r_lfsr[0] ^ r_lfsr[LFSRTAP], r_lfsr[LFSRW-1:1]};
      end
   end

   assign o_z = r_lfsr[0];

endmodule

// File: rtl/simeck_key_schedule.sv
// rtl/simeck_key_schedule.sv - iterative Simeck round-key generator; SIMECK_KS_REWIND_EN adds rewind
module simeck_key_schedule
   import simeck_pkg::*;
#(
   parameter int DATAW   = 16,
   parameter int ROUNDS  = 32,
   parameter int LFSRW   = 5,
   parameter int LFSRTAP = 2,
   localparam int IDXW   = $clog2(ROUNDS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4*DATAW-1:0] key_in,
   input  logic               key_valid,
   output logic               key_ready,
   output logic [DATAW-1:0]   rk,
   output logic [IDXW-1:0]    rk_idx,
   output logic               rk_valid,
   output logic               rk_last,
   input  logic               rk_ready
`ifdef SIMECK_KS_REWIND_EN
   ,
   input  logic               rewind
`endif
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ROUNDS - 1);

   state_t             r_state;
   logic [DATAW-1:0]   r_t [4];
   logic [IDXW-1:0]    r_cnt;

   logic               w_accept;
   logic               w_load;
   logic [4*DATAW-1:0] w_load_key;
   logic               w_hs;
   logic               w_last;
   logic               w_adv;
   logic               w_z;
   logic [DATAW-1:0]   w_f;
   logic [DATAW-1:0]   w_const;
   logic [DATAW-1:0]   w_t3_next;

   assign w_accept = (r_state == IDLE) && key_valid;

`ifdef SIMECK_KS_REWIND_EN
   logic [4*DATAW-1:0] r_shadow;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow <= '0;
      end else if (w_accept) begin
         r_shadow <= key_in;
      end
   end

   // A fresh key beats rewind in IDLE; in RUN rewind always restarts from k0.
   assign w_load     = w_accept || rewind;
   assign w_load_key = w_accept ? key_in : r_shadow;
`else
   assign w_load     = w_accept;
   assign w_load_key = key_in;
`endif

   assign w_hs      = (r_state == RUN) && rk_ready;
   assign w_last    = (r_cnt == LAST_IDX);
   assign w_adv     = w_hs && !w_last && !w_load;
   assign w_f       = DATAW'(f(64'(r_t[1]), DATAW));
   assign w_const   = DATAW'(const_base(DATAW));
   assign w_t3_next = r_t[0] ^ w_f ^ {w_const[DATAW-1:1], w_z};

   simeck_zseq #(
      .LFSRW   (LFSRW),
      .LFSRTAP (LFSRTAP)
   ) u_zseq (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_adv  (w_adv),
      .o_z    (w_z)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         for (int i = 0; i < 4; i++) r_t[i] <= '0;
      end else if (w_load) begin
         r_state <= RUN;
         r_cnt   <= '0;
         for (int i = 0; i < 4; i++) r_t[i] <= w_load_key[i*DATAW +: DATAW];
      end else if (w_hs) begin
         if (w_last) begin
            r_state <= IDLE;
         end else begin
            r_t[0] <= r_t[1];
            r_t[1] <= r_t[2];
            r_t[2] <= r_t[3];
            r_t[3] <= w_t3_next;
            r_cnt  <= r_cnt + IDXW'(1);
         end
      end
   end

   assign key_ready = (r_state == IDLE);
   assign rk_valid  = (r_state == RUN);
   assign rk        = r_t[0];
   assign rk_idx    = r_cnt;
   assign rk_last   = (r_state == RUN) && w_last;

endmodule

// File: tb/tb_simeck_key_schedule.sv
// tb/tb_simeck_key_schedule.sv - scoreboard bench for simeck_key_schedule (Simeck32/64)
module tb_simeck_key_schedule;

   localparam logic [63:0] K1    = 64'h1918_1110_0908_0100;
   localparam logic [63:0] K2    = 64'hA5C3_7E01_5A3C_81FE;
   localparam logic [31:0] Z_REF = 32'h9A42BB1F;

   typedef struct {
      logic [15:0] data;
      int          idx;
      bit          last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] key_in = '0;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic [15:0] rk;
   logic [4:0]  rk_idx;
   logic        rk_valid;
   logic        rk_last;
   logic        rk_ready = 1'b0;
   logic        rewind = 1'b0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          hs_count = 0;
   exp_t        sb[$];
   logic [15:0] hist [32];
   logic [15:0] ref_hist [32];
   logic [63:0] tb_shadow = '0;
   bit          prev_stall = 0;
   logic [15:0] prev_rk;
   logic [4:0]  prev_idx;

   simeck_key_schedule #(
      .DATAW   (16),
      .ROUNDS  (32),
      .LFSRW   (5),
      .LFSRTAP (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .rk        (rk),
      .rk_idx    (rk_idx),
      .rk_valid  (rk_valid),
      .rk_last   (rk_last),
      .rk_ready  (rk_ready)
`ifdef SIMECK_KS_REWIND_EN
      ,
      .rewind    (rewind)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mf(input logic [15:0] x);
      return (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]};
   endfunction

   task automatic push_model(input logic [63:0] key);
      logic [15:0] t0, t1, t2, t3, n;
      logic [4:0]  lfsr;
      {t3, t2, t1, t0} = key;
      lfsr = 5'h1f;
      for (int i = 0; i < 32; i++) begin
         sb.push_back('{data: t0, idx: i, last: (i == 31)});
         n    = t0 ^ mf(t1) ^ 16'hFFFC ^ {15'b0, lfsr[0]};
         t0   = t1; t1 = t2; t2 = t3; t3 = n;
         lfsr = {lfsr[0] ^ lfsr[2], lfsr[4:1]};
      end
   endtask

   always @(negedge clk) begin
      bit   reload;
      exp_t e;
      reload = 0;
      if (rst) begin
         sb.delete();
         prev_stall = 0;
         tb_shadow  = '0;
      end else begin
`ifdef SIMECK_KS_REWIND_EN
         if (rewind && !(key_valid && key_ready)) begin
            sb.delete();
            push_model(tb_shadow);
            reload = 1;
         end
`endif
         if (key_valid && key_ready) begin
            push_model(key_in);
            tb_shadow = key_in;
         end
         if (prev_stall && rk_valid) begin
            check("stall_rk", rk, prev_rk);
            check("stall_idx", rk_idx, prev_idx);
         end
         if (rk_valid && rk_ready && !reload) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               check("rk", rk, e.data);
               check("rk_idx", rk_idx, e.idx);
               check("rk_last", rk_last, e.last);
            end
            hist[rk_idx] = rk;
            hs_count++;
         end
         prev_stall = rk_valid && !rk_ready && !reload;
         prev_rk    = rk;
         prev_idx   = rk_idx;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [63:0] k);
      key_in    = k;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check("load_valid", rk_valid, 1);
      check("load_idx", rk_idx, 0);
      check("load_rk", rk, k[15:0]);
   endtask

   task automatic run_to_idle(input bit rnd, input int budget);
      int n;
      n = 0;
      do begin
         rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end while (!key_ready && n < budget);
      check("run_done", key_ready, 1);
      check("idle_valid", rk_valid, 0);
   endtask

   task automatic wait_idx(input int idx, input int budget);
      int n;
      n = 0;
      while (!(rk_valid && rk_idx == 5'(idx)) && n < budget) begin
         tick();
         n++;
      end
      check("wait_idx", rk_idx, idx);
   endtask

   initial begin
      logic [15:0] w;
      repeat (2) tick();
      check("rst_key_ready", key_ready, 1);
      check("rst_rk_valid", rk_valid, 0);
      check("rst_rk", rk, 0);
      check("rst_rk_idx", rk_idx, 0);
      check("rst_rk_last", rk_last, 0);
      rst = 1'b0;
      tick();

      // Reference run with rk_ready held high.
      rk_ready = 1'b1;
      hs_count = 0;
      load_key(K1);
      run_to_idle(0, 200);
      check("hs_count_a", hs_count, 32);
      check("sb_drain_a", sb.size(), 0);
      check("kv0", hist[0], 16'h0100);
      check("kv1", hist[1], 16'h0908);
      check("kv2", hist[2], 16'h1110);
      check("kv3", hist[3], 16'h1918);
      check("kv4", hist[4], 16'hEDED);
      for (int i = 4; i < 32; i++) begin
         w = hist[i] ^ hist[i-4] ^ mf(hist[i-3]);
         check("zbit", w, 16'hFFFC | {15'b0, Z_REF[i-4]});
      end
      for (int i = 0; i < 32; i++) ref_hist[i] = hist[i];

      // Random backpressure must yield the identical sequence.
      hs_count = 0;
      for (int i = 0; i < 32; i++) hist[i] = '0;
      load_key(K1);
      run_to_idle(1, 1000);
      check("hs_count_b", hs_count, 32);
      for (int i = 0; i < 32; i++) check("stall_seq", hist[i], ref_hist[i]);

      // key_valid held through RUN with a second key: ignored until IDLE.
      rk_ready  = 1'b1;
      key_in    = K1;
      key_valid = 1'b1;
      tick();
      key_in = K2;
      run_to_idle(0, 200);
      tick();
      key_valid = 1'b0;
      check("k2_valid", rk_valid, 1);
      check("k2_rk", rk, K2[15:0]);
      run_to_idle(0, 200);
      check("sb_drain_c", sb.size(), 0);

      // Reset in the middle of a run.
      load_key(K1);
      wait_idx(10, 100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", rk_valid, 0);
      check("mid_rst_rk", rk, 0);
      check("mid_rst_ready", key_ready, 1);
      load_key(K1);
      run_to_idle(0, 200);
      check("sb_drain_d", sb.size(), 0);

`ifdef SIMECK_KS_REWIND_EN
      load_key(K1);
      wait_idx(7, 100);
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      check("rew_rk", rk, 16'h0100);
      check("rew_idx", rk_idx, 0);
      run_to_idle(0, 200);
      for (int i = 0; i < 32; i++) hist[i] = '0;
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      check("rew_idle_valid", rk_valid, 1);
      run_to_idle(0, 200);
      for (int i = 0; i < 32; i++) check("rew_seq", hist[i], ref_hist[i]);
      check("sb_drain_e", sb.size(), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
